regfile_write_arbiter: RTL and testbench

Round-robin arbiter sharing the register file's single write port among NREQ requesters, with optional lock for back-to-back ownership. Grants one write per cycle, registers the winner's address and data, and drives the write-select input of the register file's 3-to-8 load decoder plus its write-enable and data.

---
 rtl/regfile_write_arbiter.sv | 159 +++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the register file's single write port, with per-requester
// lock so one requester can own the port for back-to-back writes.
module regfile_write_arbiter #(
    parameter int NREQ   = 4,
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ-1:0]           lock,
    input  logic [NREQ*AWIDTH-1:0]    addr,
    input  logic [NREQ*DWIDTH-1:0]    data,
    output logic [NREQ-1:0]           gnt,
    output logic                      wen,
    output logic [AWIDTH-1:0]         write,
    output logic [DWIDTH-1:0]         wdata,
    output logic [$clog2(NREQ)-1:0]   owner,
    output logic                      locked
);

    localparam int PW = $clog2(NREQ);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_LOCKED = 1'b1;

    logic [0:0]        r_state;
    logic [PW-1:0]     r_ptr;
    logic [PW-1:0]     r_owner;
    logic [NREQ-1:0]   r_gnt;
    logic              r_wen;
    logic [AWIDTH-1:0] r_write;
    logic [DWIDTH-1:0] r_wdata;

    logic [NREQ-1:0]   w_elig;
    logic              w_hi_hit;
    logic              w_lo_hit;
    int                w_hi_win;
    int                w_lo_win;
    int                w_rr_win;
    logic              w_owner_req;
    logic              w_owner_gnt;
    logic              w_grant;
    logic              w_use_rr;
    int                w_win;
    int                w_ptr_nxt;
    logic              w_win_lock;
    logic [NREQ-1:0]   w_gnt_vec;
    logic [AWIDTH-1:0] w_sel_addr;
    logic [DWIDTH-1:0] w_sel_data;
    logic [0:0]        w_state_nxt;

    always_comb begin
        // NOTE: every variable gets a default first so no path through this block infers a latch.
        w_elig   = req & ~r_gnt;
        w_hi_hit = 1'b0;
        w_hi_win = 0;
        w_lo_hit = 1'b0;
        w_lo_win = 0;
        // Descending scan: lowest eligible index at/above ptr, else lowest overall (wrap).
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_lo_hit = 1'b1;
                w_lo_win = i;
                if (i >= int'(r_ptr)) begin
                    w_hi_hit = 1'b1;
                    w_hi_win = i;
                end
            end
        end
        w_rr_win = w_hi_hit ? w_hi_win : w_lo_win;

        w_owner_req = 1'b0;
        w_owner_gnt = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (i == int'(r_owner)) begin
                w_owner_req = req[i];
                w_owner_gnt = r_gnt[i];
            end
        end

        w_grant     = 1'b0;
        w_use_rr    = 1'b0;
        w_win       = 0;
        w_state_nxt = r_state;
        if (r_state == S_IDLE) begin
            if (w_lo_hit) begin
                w_grant  = 1'b1;
                w_use_rr = 1'b1;
                w_win    = w_rr_win;
            end
        end else if (w_owner_gnt) begin
            w_grant = 1'b0;
        end else if (w_owner_req) begin
            w_grant = 1'b1;
            w_win   = int'(r_owner);
        end else begin
            // Owner let go without a pending grant: release and arbitrate this cycle.
            w_state_nxt = S_IDLE;
            if (w_lo_hit) begin
                w_grant  = 1'b1;
                w_use_rr = 1'b1;
                w_win    = w_rr_win;
            end
        end

        w_gnt_vec  = '0;
        w_win_lock = 1'b0;
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant && i == w_win) begin
                w_gnt_vec[i] = 1'b1;
                w_win_lock   = lock[i];
                w_sel_addr   = addr[i*AWIDTH +: AWIDTH];
                w_sel_data   = data[i*DWIDTH +: DWIDTH];
            end
        end
        if (w_grant) begin
            w_state_nxt = w_win_lock ? S_LOCKED : S_IDLE;
        end
        w_ptr_nxt = (w_win == NREQ - 1) ? 0 : w_win + 1;
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_gnt   <= '0;
            r_wen   <= 1'b0;
            r_write <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_vec;
            r_wen   <= w_grant;
            if (w_grant) begin
                r_write <= w_sel_addr;
                r_wdata <= w_sel_data;
                if (w_win_lock) begin
                    r_owner <= PW'(w_win);
                end
            end
            if (w_use_rr) begin
                r_ptr <= PW'(w_ptr_nxt);
            end
        end
    end

    assign gnt    = r_gnt;
    assign wen    = r_wen;
    assign write  = r_write;
    assign wdata  = r_wdata;
    assign owner  = r_owner;
    assign locked = (r_state == S_LOCKED);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: reset, single requester, wrap, fairness,
// lock ownership and release, with hand-computed expected grants.
module tb_regfile_write_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [11:0] addr;
    logic [63:0] data;
    logic [3:0]  gnt;
    logic        wen;
    logic [2:0]  write;
    logic [15:0] wdata;
    logic [1:0]  owner;
    logic        locked;

    int checks   = 0;
    int failures = 0;

    regfile_write_arbiter #(
        .NREQ   (4),
        .DWIDTH (16),
        .AWIDTH (3)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .lock   (lock),
        .addr   (addr),
        .data   (data),
        .gnt    (gnt),
        .wen    (wen),
        .write  (write),
        .wdata  (wdata),
        .owner  (owner),
        .locked (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic expect_wr(input string tag, input logic [3:0] e_gnt,
                             input logic [2:0] e_write, input logic [15:0] e_wdata);
        check({tag, "_gnt"},   32'(gnt),   32'(e_gnt));
        check({tag, "_wen"},   32'(wen),   32'(|e_gnt));
        check({tag, "_write"}, 32'(write), 32'(e_write));
        check({tag, "_wdata"}, 32'(wdata), 32'(e_wdata));
    endtask

    task automatic expect_idle(input string tag);
        check({tag, "_gnt"}, 32'(gnt), 32'(4'b0000));
        check({tag, "_wen"}, 32'(wen), 32'(1'b0));
    endtask

    task automatic expect_locked(input string tag, input logic e_locked);
        check({tag, "_locked"}, 32'(locked), 32'(e_locked));
    endtask

    task automatic expect_owner(input string tag, input logic [1:0] e_owner);
        check({tag, "_owner"}, 32'(owner), 32'(e_owner));
    endtask

    initial begin
        // Requester addresses: r3=7 r2=5 r1=6 r0=4; data r3=3333 r2=BEEF r1=1111 r0=0A0A.
        addr  = {3'd7, 3'd5, 3'd6, 3'd4};
        data  = {16'h3333, 16'hBEEF, 16'h1111, 16'h0A0A};
        reset = 1'b1;
        req   = 4'b0000;
        lock  = 4'b0000;
        step();
        expect_wr("rst0", 4'b0000, 3'd0, 16'h0000);
        expect_locked("rst0", 1'b0);
        expect_owner("rst0", 2'd0);
        reset = 1'b0;

        // Single requester 2: grant, idle, grant (every other cycle).
        req = 4'b0100;
        step(); expect_wr("single1", 4'b0100, 3'd5, 16'hBEEF);
        step(); expect_idle("single2");
        check("single2_write_hold", 32'(write), 32'(3'd5));
        check("single2_wdata_hold", 32'(wdata), 32'(16'hBEEF));
        step(); expect_wr("single3", 4'b0100, 3'd5, 16'hBEEF);
        req = 4'b0000;
        step(); expect_idle("single4");

        // Wrap: ptr=3, req 3 and 0 -> grant 3 then 0, ptr ends at 1.
        req = 4'b1001;
        step(); expect_wr("wrap3", 4'b1000, 3'd7, 16'h3333);
        step(); expect_wr("wrap0", 4'b0001, 3'd4, 16'h0A0A);
        req = 4'b0000;
        step(); expect_idle("wrap_idle");

        // Fairness from ptr=1 with all requesting: 1,2,3,0,1.
        req = 4'b1111;
        step(); expect_wr("fair1", 4'b0010, 3'd6, 16'h1111);
        step(); expect_wr("fair2", 4'b0100, 3'd5, 16'hBEEF);
        step(); expect_wr("fair3", 4'b1000, 3'd7, 16'h3333);
        step(); expect_wr("fair4", 4'b0001, 3'd4, 16'h0A0A);
        step(); expect_wr("fair5", 4'b0010, 3'd6, 16'h1111);

        // Asynchronous reset mid-stream: outputs clear without a clock edge.
        #2 reset = 1'b1;
        #1;
        expect_wr("midrst", 4'b0000, 3'd0, 16'h0000);
        expect_locked("midrst", 1'b0);
        step();
        reset = 1'b0;
        step(); expect_wr("postrst0", 4'b0001, 3'd4, 16'h0A0A);
        step(); expect_wr("postrst1", 4'b0010, 3'd6, 16'h1111);
        req = 4'b0000;
        step(); expect_idle("postrst_idle");

        // Bring ptr to 1 by granting requester 0 alone.
        req = 4'b0001;
        step(); expect_wr("setptr", 4'b0001, 3'd4, 16'h0A0A);
        req = 4'b0000;
        step(); expect_idle("setptr_idle");

        // Lock: requester 1 wins and keeps the port; requester 0 is starved meanwhile.
        req  = 4'b0011;
        lock = 4'b0010;
        step(); expect_wr("lock1", 4'b0010, 3'd6, 16'h1111);
        expect_locked("lock1", 1'b1);
        expect_owner("lock1", 2'd1);
        step(); expect_idle("lock2");
        expect_locked("lock2", 1'b1);
        step(); expect_wr("lock3", 4'b0010, 3'd6, 16'h1111);
        step(); expect_idle("lock4");
        lock = 4'b0000;
        step(); expect_wr("unlock", 4'b0010, 3'd6, 16'h1111);
        expect_locked("unlock", 1'b0);
        step(); expect_wr("after_unlock", 4'b0001, 3'd4, 16'h0A0A);
        req = 4'b0000;
        step(); expect_idle("after_unlock_idle");

        // Owner drops req while locked and not just granted: release and grant 3 same cycle.
        req  = 4'b0010;
        lock = 4'b0010;
        step(); expect_wr("drop_lock", 4'b0010, 3'd6, 16'h1111);
        expect_owner("drop_lock", 2'd1);
        step(); expect_idle("drop_wait");
        req  = 4'b1000;
        lock = 4'b0000;
        step(); expect_wr("drop_release", 4'b1000, 3'd7, 16'h3333);
        expect_locked("drop_release", 1'b0);
        req = 4'b0000;
        step(); expect_idle("drop_idle");

        // Owner drops lock and req right after its grant: idle cycle, then release.
        req  = 4'b0100;
        lock = 4'b0100;
        step(); expect_wr("both_lock", 4'b0100, 3'd5, 16'hBEEF);
        expect_owner("both_lock", 2'd2);
        req  = 4'b0000;
        lock = 4'b0000;
        step(); expect_idle("both_idle");
        expect_locked("both_idle", 1'b1);
        step(); expect_idle("both_release");
        expect_locked("both_release", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
